// File: rtl/rr_dec_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// No logic beyond the winner-search helper; no latency, no flow control.
// Not applicable: pure definitions.
package rr_dec_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Lowest offset from ptr wins, so scan offsets high-to-low and let later hits overwrite.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] idx;
        rr_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter.
// Carries no state; timing is set by the arbiter (grant 1 cycle after request).
// Requesters hold req until granted; grants are never queued.
interface rr_dec_arbiter_if;
    import rr_dec_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic               timeout;
`ifdef RR_DEC_ARBITER_LOCK_EN
    logic               lock;
`endif

    modport master (
        output req,
`ifdef RR_DEC_ARBITER_LOCK_EN
        output lock,
`endif
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req,
`ifdef RR_DEC_ARBITER_LOCK_EN
        input  lock,
`endif
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_dec_arbiter_onehot_dec2to4.sv
// 2:4 index to one-hot decoder.
// Combinational, zero latency.
// No flow control; an unknown or out-of-range index yields all zeros.
module onehot_dec2to4
    import rr_dec_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Four-requester round-robin arbiter with hold timeout; lock option via RR_DEC_ARBITER_LOCK_EN.
// Latency: registered grant one cycle after request; one forced idle cycle after every release.
// Backpressure: non-owner requests are ignored (not latched) and must be held until granted.
module rr_dec_arbiter
    import rr_dec_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    rr_dec_arbiter_if.slave arb
);

    state_t             state;
    logic [NUM_REQ-1:0] gnt_r;
    logic [ID_W-1:0]    gnt_id_r;
    logic               gnt_valid_r;
    logic               timeout_r;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic               lock_hold;
    logic               at_limit;

`ifdef RR_DEC_ARBITER_LOCK_EN
    assign lock_hold = arb.lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign win_id   = rr_pick(arb.req, ptr);
    assign at_limit = (cnt == CNT_W'(MAX_HOLD - 1));

    onehot_dec2to4 u_dec (
        .idx    (win_id),
        .onehot (win_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_r       <= '0;
            gnt_id_r    <= '0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|arb.req) begin
                        gnt_id_r    <= win_id;
                        gnt_r       <= win_onehot;
                        gnt_valid_r <= 1'b1;
                        cnt         <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Voluntary release takes priority over the timeout on the same cycle.
                    if (!arb.req[gnt_id_r] || (at_limit && !lock_hold)) begin
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        timeout_r   <= arb.req[gnt_id_r];
                        ptr         <= gnt_id_r + 2'd1;
                        state       <= IDLE;
                    end else if (!at_limit) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.gnt       = gnt_r;
    assign arb.gnt_id    = gnt_id_r;
    assign arb.gnt_valid = gnt_valid_r;
    assign arb.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Bench for rr_dec_arbiter: directed scenarios plus random requests against a tenure-level model.
module tb_rr_dec_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_dec_arbiter_if bus();

    rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: who owns the resource, how many cycles it has held it, where the search starts.
    int   m_owner;
    int   m_hold;
    int   m_ptr;
    int   m_last;
    bit   m_to;
    logic m_lock = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 2'(m_last), m_owner >= 0, m_to};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
    endfunction

    task automatic set_lock(input logic v);
        m_lock = v;
`ifdef RR_DEC_ARBITER_LOCK_EN
        bus.lock = v;
`endif
    endtask

    task automatic tick();
        logic [3:0] r;
        logic       lk;
        r  = bus.req;
        lk = m_lock;
        @(posedge clk);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (r[k] && m_owner < 0) begin
                    m_owner = k;
                    m_last  = k;
                    m_hold  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_hold >= MAX_HOLD && !lk) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_hold < MAX_HOLD) begin
            m_hold++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = 4'b1111;
        set_lock(1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        nvec++;
        if (dut_out() !== 8'h00) begin
            nerr++;
            $display("FAIL reset_async got=%b want=%b", dut_out(), 8'h00);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (dut_out() !== 8'h00) begin
            nerr++;
            $display("FAIL reset_held got=%b want=%b", dut_out(), 8'h00);
        end
        bus.req = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] order[$];
        logic [3:0] exp_ord [5];
        logic [3:0] prev;
        int         nto;
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = '0;
        nto  = 0;
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 44; c++) begin
            tick();
            nvec++;
            if (dut_out() !== model_out()) begin
                nerr++;
                $display("FAIL rotation cyc=%0d got=%b want=%b", c, dut_out(), model_out());
            end
            if (bus.gnt != 4'b0000 && prev == 4'b0000) order.push_back(bus.gnt);
            if (bus.timeout === 1'b1) nto++;
            prev = bus.gnt;
        end
        nvec++;
        if (order.size() != 5 || nto != 4) begin
            nerr++;
            $display("FAIL rotation_count tenures=%0d timeouts=%0d want 5/4", order.size(), nto);
        end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            nvec++;
            if (order[i] !== exp_ord[i]) begin
                nerr++;
                $display("FAIL rotation_order idx=%0d got=%b want=%b", i, order[i], exp_ord[i]);
            end
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_voluntary();
        int nto;
        nto = 0;
        do_reset();
        bus.req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) bus.req = 4'b0000;
            tick();
            nvec++;
            if (dut_out() !== model_out()) begin
                nerr++;
                $display("FAIL voluntary cyc=%0d got=%b want=%b", c, dut_out(), model_out());
            end
            if (c == 0) begin
                nvec++;
                if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
                    nerr++;
                    $display("FAIL voluntary_first gnt=%b id=%0d want 0100/2", bus.gnt, bus.gnt_id);
                end
            end
            if (bus.timeout === 1'b1) nto++;
        end
        nvec++;
        if (nto != 0) begin
            nerr++;
            $display("FAIL voluntary_timeout got=%0d want=0", nto);
        end
        bus.req = 4'b0101;
        tick();
        nvec++;
        if (bus.gnt !== 4'b0001 || dut_out() !== model_out()) begin
            nerr++;
            $display("FAIL ptr_wrap got=%b want gnt=0001 model=%b", dut_out(), model_out());
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            tick();
            nvec++;
            if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin
                nerr++;
                $display("FAIL simul_hold cyc=%0d got=%b want gnt=0010", c, dut_out());
            end
        end
        bus.req = 4'b1000;
        tick();
        nvec++;
        if (dut_out() !== model_out() || bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
            nerr++;
            $display("FAIL simul_release got=%b want=%b", dut_out(), model_out());
        end
        tick();
        nvec++;
        if (bus.gnt !== 4'b1000 || dut_out() !== model_out()) begin
            nerr++;
            $display("FAIL simul_next got=%b want gnt=1000", dut_out());
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        nvec++;
        if (bus.gnt !== 4'b0010) begin
            nerr++;
            $display("FAIL midreset_pre got=%b want=0010", bus.gnt);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_async got=%b want gnt=0000 valid=0 timeout=0", dut_out());
        end
        #1;
        rst_n = 1'b1;
        bus.req = 4'b1010;
        tick();
        nvec++;
        if (bus.gnt !== 4'b0010 || dut_out() !== model_out()) begin
            nerr++;
            $display("FAIL midreset_first got=%b want gnt=0010", dut_out());
        end
        bus.req = 4'b0000;
        tick();
    endtask

`ifdef RR_DEC_ARBITER_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_lock(1'b1);
        bus.req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            nvec++;
            if (bus.gnt !== 4'b0001 || bus.timeout !== 1'b0 || dut_out() !== model_out()) begin
                nerr++;
                $display("FAIL lock_hold cyc=%0d got=%b want gnt=0001 timeout=0", c, dut_out());
            end
        end
        set_lock(1'b0);
        tick();
        nvec++;
        if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin
            nerr++;
            $display("FAIL lock_drop got=%b want gnt=0000 timeout=1", dut_out());
        end
        bus.req = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        bus.req = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3, 0) == 0) bus.req = 4'($urandom_range(15, 0));
`ifdef RR_DEC_ARBITER_LOCK_EN
            if ($urandom_range(7, 0) == 0) set_lock(1'($urandom_range(1, 0)));
`endif
            tick();
            nvec++;
            if (dut_out() !== model_out()) begin
                nerr++;
                $display("FAIL random cyc=%0d req=%b got=%b want=%b", c, bus.req, dut_out(), model_out());
            end
        end
        set_lock(1'b0);
        bus.req = 4'b0000;
    endtask

    initial begin
        bus.req = 4'b0000;
        model_reset();
        test_reset();
        test_rotation();
        test_voluntary();
        test_simultaneous();
        test_reset_mid_grant();
`ifdef RR_DEC_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
